// File: rtl/adc_conv_scheduler.sv
// -----------------------------------------------------------------------------
// adc_conv_scheduler
//
// Purpose:
//   Drives the modular ADC through its Avalon-ST command/response interface.
//   Every audio sample tick issues one conversion of the audio channel. After
//   that conversion completes, one potentiometer channel is converted, with the
//   pots taken in round-robin order. Each response is checked against the
//   channel it should come from. A matching response goes either to the audio
//   output strobe or to the holding register for that pot. Overrun, timeout and
//   channel-mismatch conditions are reported on sticky flags.
//
// Handshake semantics (both directions):
//   A command transfers on a clock edge where cmd_valid & cmd_ready are both
//   high. cmd_valid and cmd_channel stay stable until that edge. There is one
//   exception: a sample tick while a pot command is still waiting is given
//   audio priority, so the pot command is withdrawn and replaced by the audio
//   command. A response is taken on any edge where rsp_valid is high. There is
//   no backpressure on the response side.
//
// Ports:
//   clk_clk, reset_reset      : clock and asynchronous active-high reset
//   sample_tick               : single-cycle audio-rate strobe
//   cmd_valid/cmd_channel/... : command stream to the ADC (sop/eop = valid)
//   cmd_ready                 : ADC command accept
//   rsp_valid/channel/data    : response stream from the ADC
//   audio_data/audio_valid    : last audio sample, with a one-cycle update pulse
//   pot_data/pot_update       : per-pot holding registers and update pulses
//   overrun/err_timeout/err_mismatch : sticky error flags
//   clear_err                 : synchronous clear of the sticky flags
//   dbg_state                 : current FSM state, for observation
// -----------------------------------------------------------------------------
module adc_conv_scheduler #(
  parameter int NUM_POTS    = 3,
  parameter int AUDIO_CH    = 1,
  parameter int POT_CH_BASE = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic                   sample_tick,
  output logic                   cmd_valid,
  output logic [4:0]             cmd_channel,
  output logic                   cmd_startofpacket,
  output logic                   cmd_endofpacket,
  input  logic                   cmd_ready,
  input  logic                   rsp_valid,
  input  logic [4:0]             rsp_channel,
  input  logic [11:0]            rsp_data,
  output logic [11:0]            audio_data,
  output logic                   audio_valid,
  output logic [12*NUM_POTS-1:0] pot_data,
  output logic [NUM_POTS-1:0]    pot_update,
  output logic                   overrun,
  output logic                   err_timeout,
  output logic                   err_mismatch,
  input  logic                   clear_err,
  output logic [2:0]             dbg_state
);

  localparam int IDX_W = (NUM_POTS > 1) ? $clog2(NUM_POTS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [4:0]       AUD_CH   = 5'(AUDIO_CH);
  localparam logic [4:0]       POT_BASE = 5'(POT_CH_BASE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_POTS - 1);
  // The timer holds 0 on the first wait cycle. The abort therefore happens on
  // the cycle where it holds TIMEOUT-1, which is the TIMEOUT-th cycle of waiting.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_AUD_CMD  = 3'd1,
    S_AUD_WAIT = 3'd2,
    S_POT_CMD  = 3'd3,
    S_POT_WAIT = 3'd4
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        pot_idx_q;
  logic                    pend_q;
  logic [TMR_W-1:0]        timer_q;
  logic                    cmd_valid_q;
  logic [4:0]              cmd_channel_q;
  logic [11:0]             audio_data_q;
  logic                    audio_valid_q;
  logic [12*NUM_POTS-1:0]  pot_data_q;
  logic [NUM_POTS-1:0]     pot_update_q;
  logic                    overrun_q;
  logic                    err_timeout_q;
  logic                    err_mismatch_q;

  logic [4:0]       pot_ch;
  logic [IDX_W-1:0] pot_idx_d;
  logic             in_wait;
  logic [4:0]       exp_ch;
  logic             rsp_match;
  logic             mismatch_evt;
  logic             timeout_evt;
  logic             overrun_evt;

  assign pot_ch    = POT_BASE + 5'(pot_idx_q);
  assign pot_idx_d = (pot_idx_q == IDX_LAST) ? '0 : pot_idx_q + IDX_W'(1);

  always_comb begin
    in_wait      = (state_q == S_AUD_WAIT) || (state_q == S_POT_WAIT);
    exp_ch       = (state_q == S_AUD_WAIT) ? AUD_CH : pot_ch;
    rsp_match    = rsp_valid && in_wait && (rsp_channel == exp_ch);
    // Any response outside a wait state is a late response. Any response
    // carrying the wrong channel is discarded. Both cases count as a mismatch.
    mismatch_evt = rsp_valid && !rsp_match;
    // A response that arrives on the expiry cycle takes precedence over the abort.
    timeout_evt  = in_wait && !rsp_valid && (timer_q == TMR_LAST);
    overrun_evt  = sample_tick && pend_q;
  end

  // Sticky flags. A clear wins over a set on the same cycle.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      overrun_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_mismatch_q <= 1'b0;
    end else if (clear_err) begin
      overrun_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_mismatch_q <= 1'b0;
    end else begin
      overrun_q      <= overrun_q      | overrun_evt;
      err_timeout_q  <= err_timeout_q  | timeout_evt;
      err_mismatch_q <= err_mismatch_q | mismatch_evt;
    end
  end

  // Main sequencer. The command outputs are registered alongside each transition.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q       <= S_IDLE;
      pot_idx_q     <= '0;
      pend_q        <= 1'b0;
      timer_q       <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_channel_q <= '0;
      audio_data_q  <= '0;
      audio_valid_q <= 1'b0;
      pot_data_q    <= '0;
      pot_update_q  <= '0;
    end else begin
      audio_valid_q <= 1'b0;
      pot_update_q  <= '0;

      case (state_q)
        S_IDLE: begin
          if (sample_tick || pend_q) begin
            state_q       <= S_AUD_CMD;
            pend_q        <= 1'b0;
            cmd_valid_q   <= 1'b1;
            cmd_channel_q <= AUD_CH;
          end
        end

        S_AUD_CMD: begin
          if (sample_tick) pend_q <= 1'b1;
          if (cmd_ready) begin
            state_q       <= S_AUD_WAIT;
            timer_q       <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_channel_q <= '0;
          end
        end

        S_AUD_WAIT: begin
          if (sample_tick) pend_q <= 1'b1;
          if (rsp_valid) begin
            if (rsp_match) begin
              audio_data_q  <= rsp_data;
              audio_valid_q <= 1'b1;
            end
            state_q       <= S_POT_CMD;
            cmd_valid_q   <= 1'b1;
            cmd_channel_q <= pot_ch;
          end else if (timer_q == TMR_LAST) begin
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        S_POT_CMD: begin
          if (cmd_ready) begin
            // If the command was accepted on this edge, the tick cannot
            // preempt it. Hold the tick in the pending slot instead.
            if (sample_tick) pend_q <= 1'b1;
            state_q       <= S_POT_WAIT;
            timer_q       <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_channel_q <= '0;
          end else if (sample_tick) begin
            // Audio priority. Withdraw the pot command and leave pot_idx as it
            // is, so the same pot is retried after this audio conversion.
            state_q       <= S_AUD_CMD;
            cmd_channel_q <= AUD_CH;
          end
        end

        S_POT_WAIT: begin
          if (sample_tick) pend_q <= 1'b1;
          if (rsp_valid) begin
            if (rsp_match) begin
              pot_data_q[12*int'(pot_idx_q) +: 12] <= rsp_data;
              pot_update_q[pot_idx_q]              <= 1'b1;
            end
            pot_idx_q <= pot_idx_d;
            state_q   <= S_IDLE;
          end else if (timer_q == TMR_LAST) begin
            pot_idx_q <= pot_idx_d;
            state_q   <= S_IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        default: begin
          state_q       <= S_IDLE;
          cmd_valid_q   <= 1'b0;
          cmd_channel_q <= '0;
        end
      endcase
    end
  end

  assign cmd_valid         = cmd_valid_q;
  assign cmd_channel       = cmd_channel_q;
  assign cmd_startofpacket = cmd_valid_q;
  assign cmd_endofpacket   = cmd_valid_q;
  assign audio_data        = audio_data_q;
  assign audio_valid       = audio_valid_q;
  assign pot_data          = pot_data_q;
  assign pot_update        = pot_update_q;
  assign overrun           = overrun_q;
  assign err_timeout       = err_timeout_q;
  assign err_mismatch      = err_mismatch_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// -----------------------------------------------------------------------------
// tb_adc_conv_scheduler
//
// A directed sequence plays the ADC side of the interface. Expected audio
// samples and expected pot updates are queued when the matching response is
// driven. A monitor pops an entry from the queue whenever the DUT pulses an
// update strobe. Inputs change on the falling edge and outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_adc_conv_scheduler;

  localparam int NP = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sample_tick = 1'b0;
  logic           cmd_valid;
  logic [4:0]     cmd_channel;
  logic           cmd_sop;
  logic           cmd_eop;
  logic           cmd_ready = 1'b0;
  logic           rsp_valid = 1'b0;
  logic [4:0]     rsp_channel = '0;
  logic [11:0]    rsp_data = '0;
  logic [11:0]    audio_data;
  logic           audio_valid;
  logic [12*NP-1:0] pot_data;
  logic [NP-1:0]  pot_update;
  logic           overrun;
  logic           err_timeout;
  logic           err_mismatch;
  logic           clear_err = 1'b0;
  logic [2:0]     dbg_state;

  int total = 0;
  int bad   = 0;

  logic [11:0] aud_q[$];
  logic [15:0] pot_q[$];

  adc_conv_scheduler #(
    .NUM_POTS(NP), .AUDIO_CH(1), .POT_CH_BASE(2), .TIMEOUT(255)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .sample_tick(sample_tick),
    .cmd_valid(cmd_valid), .cmd_channel(cmd_channel),
    .cmd_startofpacket(cmd_sop), .cmd_endofpacket(cmd_eop),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel),
    .rsp_data(rsp_data), .audio_data(audio_data), .audio_valid(audio_valid),
    .pot_data(pot_data), .pot_update(pot_update), .overrun(overrun),
    .err_timeout(err_timeout), .err_mismatch(err_mismatch),
    .clear_err(clear_err), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [11:0] ea;
    logic [15:0] ep;
    logic [NP-1:0] m;
    int idx;
    if (audio_valid === 1'b1) begin
      chk("aud_expected", 64'(aud_q.size() != 0), 64'd1);
      if (aud_q.size() != 0) begin
        ea = aud_q.pop_front();
        chk("aud_data", 64'(audio_data), 64'(ea));
      end
    end
    if (pot_update !== '0) begin
      chk("pot_expected", 64'(pot_q.size() != 0), 64'd1);
      if (pot_q.size() != 0) begin
        ep  = pot_q.pop_front();
        idx = int'(ep[15:12]);
        m   = NP'(1) << idx;
        chk("pot_strobe", 64'(pot_update), 64'(m));
        chk("pot_data", 64'(pot_data[idx*12 +: 12]), 64'(ep[11:0]));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
  endtask

  task automatic wait_cmd(input logic [4:0] ch, input string tag);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(cmd_valid), 64'd1);
    chk({tag, "_chan"}, 64'(cmd_channel), 64'(ch));
    chk({tag, "_sop_eop"}, 64'({cmd_sop, cmd_eop}), 64'd3);
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic respond(input logic [4:0] ch, input logic [11:0] d, input int dly);
    repeat (dly) @(negedge clk);
    rsp_valid = 1'b1; rsp_channel = ch; rsp_data = d;
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  task automatic wait_timeout(input string tag);
    int n = 0;
    while (err_timeout !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n), 64'd255);
  endtask

  // One audio conversion followed by one pot conversion, both answered normally
  task automatic conv(input logic [11:0] aud, input int pidx, input logic [11:0] pv,
                      input string tag);
    tick();
    wait_cmd(5'd1, {tag, "_aud_cmd"});
    accept();
    aud_q.push_back(aud);
    respond(5'd1, aud, int'($urandom_range(1, 30)));
    wait_cmd(5'(2 + pidx), {tag, "_pot_cmd"});
    accept();
    pot_q.push_back({4'(pidx), pv});
    respond(5'(2 + pidx), pv, int'($urandom_range(1, 30)));
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int seen;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_flags", 64'({overrun, err_timeout, err_mismatch}), 64'd0);
    chk("rst_outputs", 64'({audio_data, audio_valid, pot_update}), 64'd0);
    chk("rst_pot_data", 64'(pot_data), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // First tick: audio on channel 1 after 20 cycles, then pot 0 on channel 2
    tick();
    wait_cmd(5'd1, "t1_aud_cmd");
    accept();
    chk("t1_cmd_dropped", 64'(cmd_valid), 64'd0);
    aud_q.push_back(12'hABC);
    respond(5'd1, 12'hABC, 20);
    chk("t1_audio_data", 64'(audio_data), 64'hABC);
    wait_cmd(5'd2, "t1_pot_cmd");
    accept();
    pot_q.push_back({4'd0, 12'h100});
    respond(5'd2, 12'h100, 7);
    repeat (200) @(negedge clk);

    // Round-robin across the pots, with the second update landing on pot 0
    conv(12'h011, 1, 12'h200, "t2a");
    repeat (190) @(negedge clk);
    conv(12'h022, 2, 12'h300, "t2b");
    repeat (190) @(negedge clk);
    conv(12'h033, 0, 12'h111, "t2c");
    chk("t2_pot_data", 64'(pot_data), 64'h300200111);

    // Pot command held off, then a tick preempts it
    tick();
    wait_cmd(5'd1, "t3_aud_cmd");
    accept();
    aud_q.push_back(12'h044);
    respond(5'd1, 12'h044, 4);
    wait_cmd(5'd3, "t3_pot_cmd");
    repeat (10) @(negedge clk);
    chk("t3_pot_hold", 64'({cmd_valid, cmd_channel}), 64'({1'b1, 5'd3}));
    tick();
    wait_cmd(5'd1, "t3_preempt");
    accept();
    aud_q.push_back(12'h055);
    respond(5'd1, 12'h055, 6);
    wait_cmd(5'd3, "t3_pot_retry");
    accept();
    pot_q.push_back({4'd1, 12'h222});
    respond(5'd3, 12'h222, 3);
    repeat (5) @(negedge clk);

    // Two ticks while audio is outstanding: one extra conversion and an overrun
    tick();
    wait_cmd(5'd1, "t4_aud_cmd");
    accept();
    tick();
    tick();
    chk("t4_overrun", 64'(overrun), 64'd1);
    aud_q.push_back(12'h0A1);
    respond(5'd1, 12'h0A1, 5);
    wait_cmd(5'd4, "t4_pot_cmd");
    accept();
    pot_q.push_back({4'd2, 12'h333});
    respond(5'd4, 12'h333, 5);
    wait_cmd(5'd1, "t4_extra_aud");
    accept();
    aud_q.push_back(12'h0A2);
    respond(5'd1, 12'h0A2, 5);
    wait_cmd(5'd2, "t4_extra_pot");
    accept();
    pot_q.push_back({4'd0, 12'h444});
    respond(5'd2, 12'h444, 5);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) seen = 1;
    end
    chk("t4_no_third_conv", 64'(seen), 64'd0);
    chk("t4_overrun_sticky", 64'(overrun), 64'd1);
    pulse_clear();
    chk("t4_overrun_clear", 64'(overrun), 64'd0);

    // Audio timeout, then a normal conversion
    tick();
    wait_cmd(5'd1, "t5_aud_cmd");
    accept();
    wait_timeout("t5_aud_timeout_cycles");
    chk("t5_idle", 64'({dbg_state, cmd_valid}), 64'd0);
    pulse_clear();
    chk("t5_timeout_clear", 64'(err_timeout), 64'd0);
    tick();
    wait_cmd(5'd1, "t5_aud_cmd2");
    accept();
    aud_q.push_back(12'h5A5);
    respond(5'd1, 12'h5A5, 9);
    // Pot timeout advances the index, and a late response flags a mismatch
    wait_cmd(5'd3, "t5_pot_cmd");
    accept();
    wait_timeout("t5_pot_timeout_cycles");
    respond(5'd3, 12'h999, 1);
    chk("t5_late_mismatch", 64'(err_mismatch), 64'd1);
    chk("t5_pot_data", 64'(pot_data), 64'h333222444);
    pulse_clear();
    chk("t5_flags_clear", 64'({err_timeout, err_mismatch}), 64'd0);

    // A clear on the same cycle as an event wins, and the next event sets the flag
    @(negedge clk);
    rsp_valid = 1'b1; rsp_channel = 5'd1; clear_err = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0; clear_err = 1'b0;
    chk("clr_priority", 64'(err_mismatch), 64'd0);
    respond(5'd1, 12'h000, 0);
    chk("clr_next_sets", 64'(err_mismatch), 64'd1);
    pulse_clear();

    // Audio response carrying the wrong channel
    tick();
    wait_cmd(5'd1, "t6_aud_cmd");
    accept();
    respond(5'd3, 12'h777, 10);
    chk("t6_mismatch", 64'(err_mismatch), 64'd1);
    chk("t6_audio_kept", 64'(audio_data), 64'h5A5);
    wait_cmd(5'd4, "t6_pot_cmd");
    accept();
    pot_q.push_back({4'd2, 12'h555});
    respond(5'd4, 12'h555, 2);
    pulse_clear();

    // A response on the expiry cycle beats the timeout
    tick();
    wait_cmd(5'd1, "edge_aud_cmd");
    accept();
    aud_q.push_back(12'h321);
    respond(5'd1, 12'h321, 254);
    chk("edge_no_timeout", 64'(err_timeout), 64'd0);
    chk("edge_audio_data", 64'(audio_data), 64'h321);
    wait_cmd(5'd2, "edge_pot_cmd");
    accept();
    pot_q.push_back({4'd0, 12'h666});
    respond(5'd2, 12'h666, 2);
    repeat (3) @(negedge clk);
    chk("final_pot_data", 64'(pot_data), 64'h555222666);

    // Reset during a conversion, and the first response after it counts as late
    tick();
    wait_cmd(5'd1, "rst_mid_cmd");
    accept();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_state", 64'({dbg_state, cmd_valid}), 64'd0);
    chk("rst_mid_data", 64'({audio_data, pot_data}), 64'd0);
    rst = 1'b0;
    respond(5'd1, 12'hFFF, 2);
    chk("rst_mid_late", 64'(err_mismatch), 64'd1);
    chk("rst_mid_audio", 64'(audio_data), 64'd0);
    repeat (5) @(negedge clk);

    chk("aud_q_drained", 64'(aud_q.size()), 64'd0);
    chk("pot_q_drained", 64'(pot_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
